// File: rtl/clk_gate_ctrl_if.sv
// Signal bundle between the gated-domain logic and clk_gate_ctrl.
// The gated-cycle statistics signals exist only when CLK_GATE_CTRL_STATS_EN is defined.
interface clk_gate_ctrl_if #(
    parameter int StatWidth = 32
);
    logic busy_i;
    logic force_on_i;
    logic wake_req_i;
    logic wake_gnt_o;
    logic en_o;
    logic gated_o;
`ifdef CLK_GATE_CTRL_STATS_EN
    logic                 stat_clr_i;
    logic [StatWidth-1:0] stat_gated_cycles_o;

    modport master (
        output busy_i, force_on_i, wake_req_i, stat_clr_i,
        input  wake_gnt_o, en_o, gated_o, stat_gated_cycles_o
    );
    modport slave (
        input  busy_i, force_on_i, wake_req_i, stat_clr_i,
        output wake_gnt_o, en_o, gated_o, stat_gated_cycles_o
    );
`else
    modport master (
        output busy_i, force_on_i, wake_req_i,
        input  wake_gnt_o, en_o, gated_o
    );
    modport slave (
        input  busy_i, force_on_i, wake_req_i,
        output wake_gnt_o, en_o, gated_o
    );
`endif

    if (StatWidth < 1) begin : g_bad_stat_width
        $error("clk_gate_ctrl_if: StatWidth must be >= 1");
    end
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-detection enable generator feeding an ICG cell; runs on the free-running clock.
// Optional gated-cycle counter is built when CLK_GATE_CTRL_STATS_EN is defined.
module clk_gate_ctrl #(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2,
    parameter int StatWidth  = 32
) (
    input logic            clk_i,
    input logic            rst_i,
    clk_gate_ctrl_if.slave bus
);
    localparam int IdleW = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
    localparam int WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'((IdleCycles > 0) ? IdleCycles - 1 : 0);
    localparam logic [WakeW-1:0] WakeLast = WakeW'((WakeCycles > 0) ? WakeCycles - 1 : 0);

    if (WakeCycles < 1) begin : g_bad_wake_cycles
        $error("clk_gate_ctrl: WakeCycles must be >= 1");
    end
    if (StatWidth < 1) begin : g_bad_stat_width
        $error("clk_gate_ctrl: StatWidth must be >= 1");
    end

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        GATED  = 2'd1,
        WAKE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
    logic             en_q, gated_q;
    logic             idle;

    assign idle = !bus.busy_i && !bus.wake_req_i && !bus.force_on_i;

    // Any non-idle cycle restarts the idle streak, so a wake event on the threshold cycle prevents gating.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ACTIVE: begin
                if (!idle || IdleCycles == 0) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IdleLast) begin
                    state_d    = GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
            GATED: begin
                if (!idle) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WakeLast) begin
                    state_d    = ACTIVE;
                    idle_cnt_d = '0;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WakeW'(1);
                end
            end
            default: begin
                state_d    = ACTIVE;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // en_o and gated_o come straight from flops so the ICG enable can never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            en_q       <= (state_d != GATED);
            gated_q    <= (state_d == GATED);
        end
    end

    assign bus.en_o       = en_q;
    assign bus.gated_o    = gated_q;
    assign bus.wake_gnt_o = bus.wake_req_i && (state_q == ACTIVE);

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [StatWidth-1:0] stat_q, stat_d;

    // Saturating count of cycles with the clock gated; clear takes priority.
    always_comb begin
        stat_d = stat_q;
        if (bus.stat_clr_i) begin
            stat_d = '0;
        end else if (!en_q && !(&stat_q)) begin
            stat_d = stat_q + StatWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.stat_gated_cycles_o = stat_q;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with a cycle-level reference model and literal checkpoints.
// Define CLK_GATE_CTRL_STATS_EN to also exercise the gated-cycle counter.
module tb_clk_gate_ctrl;
    localparam int IdleCycles = 4;
    localparam int WakeCycles = 2;
    localparam int StatWidth  = 4;
    localparam int StatMax    = (1 << StatWidth) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic statClr = 1'b0;
    int   checks = 0;
    int   passes = 0;

    clk_gate_ctrl_if #(.StatWidth(StatWidth)) bus ();
    clk_gate_ctrl_if #(.StatWidth(StatWidth)) bus0 ();

    clk_gate_ctrl #(
        .IdleCycles(IdleCycles),
        .WakeCycles(WakeCycles),
        .StatWidth (StatWidth)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    clk_gate_ctrl #(
        .IdleCycles(0),
        .WakeCycles(WakeCycles),
        .StatWidth (StatWidth)
    ) dutNever (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus0)
    );

    assign bus0.busy_i     = bus.busy_i;
    assign bus0.force_on_i = bus.force_on_i;
    assign bus0.wake_req_i = bus.wake_req_i;
`ifdef CLK_GATE_CTRL_STATS_EN
    assign bus.stat_clr_i  = statClr;
    assign bus0.stat_clr_i = statClr;
`endif

    always #5 clk = ~clk;

    // Reference model: where the controller is in its life cycle, by counting cycles.
    bit mActive = 1'b1;
    bit mGated = 1'b0;
    int idleStreak = 0;
    int wakeLeft = 0;
    int mStat = 0;
    bit started = 1'b0;

    always @(posedge clk) begin
        bit quiet;
        quiet = !bus.busy_i && !bus.wake_req_i && !bus.force_on_i;
        if (rst) begin
            mActive = 1'b1;
            mGated = 1'b0;
            idleStreak = 0;
            wakeLeft = 0;
            mStat = 0;
            started = 1'b1;
        end else begin
            if (statClr) mStat = 0;
            else if (mGated && mStat < StatMax) mStat = mStat + 1;
            if (mActive) begin
                if (!quiet) begin
                    idleStreak = 0;
                end else begin
                    idleStreak = idleStreak + 1;
                    if (idleStreak == IdleCycles) begin
                        mActive = 1'b0;
                        mGated = 1'b1;
                        idleStreak = 0;
                    end
                end
            end else if (mGated) begin
                if (!quiet) begin
                    mGated = 1'b0;
                    wakeLeft = WakeCycles;
                end
            end else begin
                wakeLeft = wakeLeft - 1;
                if (wakeLeft == 0) mActive = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic b, input logic f, input logic r, input logic c, input int n);
        bus.busy_i     = b;
        bus.force_on_i = f;
        bus.wake_req_i = r;
        statClr        = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput("model_en_o", {31'd0, bus.en_o}, {31'd0, !mGated});
            checkOutput("model_gated_o", {31'd0, bus.gated_o}, {31'd0, mGated});
            checkOutput("model_wake_gnt_o", {31'd0, bus.wake_gnt_o}, {31'd0, bus.wake_req_i && mActive});
            checkOutput("never_en_o", {31'd0, bus0.en_o}, 32'd1);
            checkOutput("never_gated_o", {31'd0, bus0.gated_o}, 32'd0);
            checkOutput("never_wake_gnt_o", {31'd0, bus0.wake_gnt_o}, {31'd0, bus.wake_req_i});
`ifdef CLK_GATE_CTRL_STATS_EN
            checkOutput("model_stat", 32'(bus.stat_gated_cycles_o), mStat);
`endif
        end
    end

    initial begin
        bus.busy_i     = 1'b1;
        bus.force_on_i = 1'b0;
        bus.wake_req_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_en", {31'd0, bus.en_o}, 32'd1);
        checkOutput("reset_gated", {31'd0, bus.gated_o}, 32'd0);
        checkOutput("reset_gnt", {31'd0, bus.wake_gnt_o}, 32'd0);
        rst = 1'b0;

        $display("[TB] gate after idle");
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("gate_before", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("gate_en", {31'd0, bus.en_o}, 32'd0);
        checkOutput("gate_gated", {31'd0, bus.gated_o}, 32'd1);

        $display("[TB] idle blip");
        applyStimulus(1, 0, 0, 0, 4);
        checkOutput("blip_woken", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 3);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("blip_held", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("blip_gated", {31'd0, bus.en_o}, 32'd0);

        $display("[TB] wake handshake");
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("wake_en", {31'd0, bus.en_o}, 32'd1);
        checkOutput("wake_gnt_early1", {31'd0, bus.wake_gnt_o}, 32'd0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("wake_gnt_early2", {31'd0, bus.wake_gnt_o}, 32'd0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("wake_gnt", {31'd0, bus.wake_gnt_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wake_gnt_drop", {31'd0, bus.wake_gnt_o}, 32'd0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("active_gnt_same_cycle", {31'd0, bus.wake_gnt_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] force on");
        applyStimulus(0, 1, 0, 0, 20);
        checkOutput("force_hold", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("force_release_held", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("force_release_gated", {31'd0, bus.en_o}, 32'd0);

        $display("[TB] reset during wake");
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("rst_wake_en", {31'd0, bus.en_o}, 32'd1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_mid_en", {31'd0, bus.en_o}, 32'd1);
        checkOutput("rst_mid_gated", {31'd0, bus.gated_o}, 32'd0);
        checkOutput("rst_mid_gnt", {31'd0, bus.wake_gnt_o}, 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("rst_after_held", {31'd0, bus.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_after_gated", {31'd0, bus.en_o}, 32'd0);

`ifdef CLK_GATE_CTRL_STATS_EN
        $display("[TB] gated-cycle counter");
        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("stat_saturated", 32'(bus.stat_gated_cycles_o), 32'd15);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("stat_cleared", 32'(bus.stat_gated_cycles_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("stat_restart", 32'(bus.stat_gated_cycles_o), 32'd1);
`endif

        checkOutput("never_gate_en", {31'd0, bus0.en_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
